// File: rtl/sextium_sram_pkg.sv
// Shared types and helpers for the sextium SRAM bridge: FSM state encoding,
// wait-counter sizing and byte-enable constants.
package sextium_sram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TURN_WAIT = 3'd1,
      ST_RD        = 3'd2,
      ST_WR_SETUP  = 3'd3,
      ST_WR_PULSE  = 3'd4,
      ST_WR_HOLD   = 3'd5,
      ST_DONE      = 3'd6
   } sram_state_e;

   // Byte-enable constants sized for the widest supported bus (128 bits);
   // users slice the low DATA_W/8 bits.
   localparam int unsigned BE_MAX_W = 128 / 8;
   localparam logic [BE_MAX_W-1:0] BE_ALL_ON  = '0;
   localparam logic [BE_MAX_W-1:0] BE_ALL_OFF = '1;

   function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                             input int unsigned wr_wait,
                                             input int unsigned turn);
      int unsigned m;
      m = rd_wait;
      if (wr_wait > m) m = wr_wait;
      if (turn > m)    m = turn;
      return $clog2(m + 32'd1);
   endfunction

endpackage

// File: rtl/sextium_wait_timer.sv
// Loadable down-counter with a zero flag, shared by every timed FSM state.
module sextium_wait_timer #(
   parameter int unsigned CW = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign zero_o = (cnt_q == '0);

   // Next count: load wins, decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && !zero_o) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sextium_sram_ctrl.sv
// Bridge from the sextium_core mem_read/mem_write/mem_ack handshake to an
// asynchronous SRAM, with programmable wait states and bus turnaround.
module sextium_sram_ctrl
   import sextium_sram_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SRAM_ADDR_W = 20,
   parameter int unsigned RD_WAIT     = 2,
   parameter int unsigned WR_WAIT     = 2,
   parameter int unsigned TURN        = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [ADDR_W-1:0]      addr_bus,
   input  logic [DATA_W-1:0]      mem_bus_out,
   output logic [DATA_W-1:0]      mem_bus_in,
   output logic                   mem_ack,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [DATA_W-1:0]      sram_dq_in,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic [DATA_W/8-1:0]    sram_be_n,
   output logic                   busy,
   output logic                   err
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned CW   = cnt_width(RD_WAIT, WR_WAIT, TURN);
   localparam logic [CW-1:0] RD_LD   = CW'(RD_WAIT - 32'd1);
   localparam logic [CW-1:0] WR_LD   = CW'(WR_WAIT - 32'd1);
   localparam logic [CW-1:0] TURN_LD = (TURN > 32'd0) ? CW'(TURN - 32'd1) : '0;
   localparam bit            HAS_TURN = (TURN > 32'd0);
   localparam logic [BE_W-1:0] BE_ON  = BE_ALL_ON[BE_W-1:0];
   localparam logic [BE_W-1:0] BE_OFF = BE_ALL_OFF[BE_W-1:0];

   sram_state_e            state_q;
   logic [DATA_W-1:0]      rdata_q;
   logic                   ack_q;
   logic [SRAM_ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0]      dq_out_q;
   logic                   dq_oe_q;
   logic                   ce_n_q;
   logic                   oe_n_q;
   logic                   we_n_q;
   logic [BE_W-1:0]        be_n_q;
   logic                   busy_q;
   logic                   err_q;
   logic                   last_wr_q;

   logic          tmr_load_s;
   logic [CW-1:0] tmr_val_s;
   logic          tmr_dec_s;
   logic          tmr_zero_s;

   // Timer is reloaded on entry to each timed state and counts down inside it.
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = '0;
      tmr_dec_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!mem_write && mem_read) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = (last_wr_q && HAS_TURN) ? TURN_LD : RD_LD;
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         ST_TURN_WAIT: begin
            if (tmr_zero_s) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = RD_LD;
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         ST_RD:       tmr_dec_s = 1'b1;
         ST_WR_SETUP: begin
            tmr_load_s = 1'b1;
            tmr_val_s  = WR_LD;
         end
         ST_WR_PULSE: tmr_dec_s = 1'b1;
         default:     tmr_load_s = 1'b0;
      endcase
   end

   sextium_wait_timer #(.CW(CW)) u_timer (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .dec_i      (tmr_dec_s),
      .zero_o     (tmr_zero_s)
   );

   // Access sequencer; every SRAM strobe is a register written here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         addr_q    <= '0;
         dq_out_q  <= '0;
         dq_oe_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         be_n_q    <= BE_OFF;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         last_wr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q <= 1'b0;
               if (mem_write) begin
                  err_q    <= err_q | mem_read;
                  addr_q   <= SRAM_ADDR_W'(addr_bus);
                  dq_out_q <= mem_bus_out;
                  dq_oe_q  <= 1'b1;
                  ce_n_q   <= 1'b0;
                  be_n_q   <= BE_ON;
                  busy_q   <= 1'b1;
                  state_q  <= ST_WR_SETUP;
               end else if (mem_read) begin
                  addr_q <= SRAM_ADDR_W'(addr_bus);
                  ce_n_q <= 1'b0;
                  be_n_q <= BE_ON;
                  busy_q <= 1'b1;
                  if (last_wr_q && HAS_TURN) begin
                     state_q <= ST_TURN_WAIT;
                  end else begin
                     oe_n_q  <= 1'b0;
                     state_q <= ST_RD;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_TURN_WAIT: begin
               if (tmr_zero_s) begin
                  oe_n_q  <= 1'b0;
                  state_q <= ST_RD;
               end else begin
                  state_q <= ST_TURN_WAIT;
               end
            end
            ST_RD: begin
               if (tmr_zero_s) begin
                  rdata_q   <= sram_dq_in;
                  oe_n_q    <= 1'b1;
                  ack_q     <= 1'b1;
                  last_wr_q <= 1'b0;
                  state_q   <= ST_DONE;
               end else begin
                  state_q <= ST_RD;
               end
            end
            ST_WR_SETUP: begin
               we_n_q  <= 1'b0;
               state_q <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (tmr_zero_s) begin
                  we_n_q  <= 1'b1;
                  state_q <= ST_WR_HOLD;
               end else begin
                  state_q <= ST_WR_PULSE;
               end
            end
            ST_WR_HOLD: begin
               dq_oe_q   <= 1'b0;
               ack_q     <= 1'b1;
               last_wr_q <= 1'b1;
               state_q   <= ST_DONE;
            end
            ST_DONE: begin
               ack_q   <= 1'b0;
               ce_n_q  <= 1'b1;
               be_n_q  <= BE_OFF;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               ack_q   <= 1'b0;
               dq_oe_q <= 1'b0;
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
               be_n_q  <= BE_OFF;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_bus_in  = rdata_q;
   assign mem_ack     = ack_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_be_n   = be_n_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule

// File: doc/sextium_sram_ctrl.md
Name: sextium_sram_ctrl

Overview:
Parametrised bridge between the sextium_core memory handshake (mem_read/mem_write/mem_ack) and an external asynchronous SRAM of the simulated_sram/DE2 kind.
- Replaces the fixed Qsys SRAM bridge path.
- Configurable data width, address width, read/write wait states and bus-turnaround cycles.
- Adds a busy indication and a sticky protocol-error flag.
- All SRAM control outputs are registered.

Parameters:
DATA_W, 16, data width; must be a multiple of 8.
ADDR_W, 16, core address width.
SRAM_ADDR_W, 20, SRAM word-address width; must satisfy ADDR_W <= SRAM_ADDR_W.
RD_WAIT, 2, cycles OE_n is held low before read data is sampled; minimum 1.
WR_WAIT, 2, cycles WE_n is held low; minimum 1.
TURN, 1, idle cycles inserted between a write and a following read; 0 allowed.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mem_read  in  1  core read request; held with addr_bus until ack
mem_write  in  1  core write request; held with addr_bus and mem_bus_out until ack
addr_bus  in  ADDR_W  word address
mem_bus_out  in  DATA_W  write data from core
mem_bus_in  out  DATA_W  read data to core
mem_ack  out  1  one-cycle completion pulse
sram_addr  out  SRAM_ADDR_W  SRAM address
sram_dq_out  out  DATA_W  data to drive onto SRAM_DQ
sram_dq_oe  out  1  tristate enable for sram_dq_out
sram_dq_in  in  DATA_W  data sampled from SRAM_DQ
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  DATA_W/8  byte enables, active low
busy  out  1  high in every state except IDLE
err  out  1  sticky: mem_read and mem_write were seen together

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values (next edge with reset high):
  - mem_ack=0, mem_bus_in=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=all 1.
  - busy=0, err=0, FSM=IDLE, last_was_write=0.
- Reset mid-operation aborts immediately:
  - WE_n/OE_n/CE_n high and dq released on the next edge.
  - No mem_ack is issued.
- States: IDLE, TURN_WAIT, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: requests are sampled at the clock edge.
  - mem_write has priority. If mem_read is also high, err is set and stays set until reset.
  - On any request, latch sram_addr = zero-extended addr_bus.
  - On a write, also latch sram_dq_out = mem_bus_out.
  - sram_ce_n=0 and sram_be_n=all 0 from the next cycle until leaving DONE.
- Read path:
  - If last_was_write and TURN>0, go to TURN_WAIT for TURN cycles: oe_n=1, dq_oe=0. Otherwise go straight to RD.
  - RD lasts RD_WAIT cycles with oe_n=0.
  - mem_bus_in is loaded from sram_dq_in at the last RD edge.
  - Then DONE; clear last_was_write.
- Write path:
  - WR_SETUP: 1 cycle, dq_oe=1, we_n=1.
  - WR_PULSE: WR_WAIT cycles, we_n=0.
  - WR_HOLD: 1 cycle, we_n=1, dq_oe=1, address and data still stable.
  - Then DONE; set last_was_write.
- DONE: mem_ack=1 for exactly one cycle, dq_oe=0, oe_n=1, ce_n=1 from the next edge; then IDLE.
- Requests are not sampled during DONE. The core drops its request in the cycle after DONE, before IDLE samples.
- Latency, counted from the IDLE sampling edge:
  - Read without turnaround: ack in cycle RD_WAIT+1.
  - Read after a write: ack in cycle TURN+RD_WAIT+1.
  - Write: ack in cycle WR_WAIT+3.
  - Back-to-back accesses: minimum one IDLE cycle between acks.
- mem_bus_in holds the last read value until the next read completes; writes never change it.
- Invariants:
  - sram_we_n and sram_oe_n are never low in the same cycle.
  - sram_dq_oe is never high while sram_oe_n is low.
- Wait counter width is $clog2(max(RD_WAIT,WR_WAIT,TURN)+1); it is reloaded on each state entry.

Decomposition:
- Package sextium_sram_pkg holds:
  - state enumeration;
  - a function computing the counter width;
  - constants BE_ALL_ON / BE_ALL_OFF, derived from DATA_W/8.
- One natural sub-module, sextium_wait_timer:
  - loadable down-counter with a zero flag;
  - shared by TURN_WAIT, RD and WR_PULSE.
- All other logic is a single FSM in sextium_sram_ctrl.

Test Plan:
- Reset held 3 cycles, then released -> all outputs at their reset values; busy=0; no SRAM strobes.
- Defaults: write addr 0x0012 data 0xBEEF -> we_n low for exactly 2 cycles with sram_addr=0x00012 and dq_oe high from WR_SETUP through WR_HOLD; ack in cycle 5 → read 0x0012 -> after 1 TURN cycle, oe_n low for 2 cycles; mem_bus_in=0xBEEF with ack in cycle 4.
- Read 0x0012 then read 0x0034 (SRAM preloaded 0x1234) -> no turnaround; acks in cycle 3 of each access; mem_bus_in=0xBEEF then 0x1234.
- RD_WAIT=4, WR_WAIT=1, TURN=0: write then read -> write ack in cycle 4, read ack in cycle 5; oe_n/we_n never low together.
- mem_read and mem_write asserted together, addr 0x0001 data 0x00AA -> write performed, err=1 and stays 1 through later accesses until reset.
- Reset asserted during WR_PULSE -> next cycle we_n=1, ce_n=1, dq_oe=0, no ack; a following read returns the old contents at that address.
